// File: rtl/bch_pkg.sv
// bch_pkg: shared constants, types and helper functions for the BCH(63,51)
// encoder (t=2, g(x) = x^12+x^10+x^8+x^5+x^4+x^3+1).
//   N        codeword length
//   K        message length
//   PAR_W    parity width
//   GEN_POLY generator polynomial bits [12:0], x^12 down to x^0
//   state_t  serial encoder states (MSG, PAR)
//   bch_step one division step of the systematic encoder LFSR
//   bch_parity remainder of msg(x)*x^12 mod g(x)
package bch_pkg;

    localparam int N     = 63;
    localparam int K     = 51;
    localparam int PAR_W = 12;

    localparam logic [PAR_W:0] GEN_POLY = 13'h1539;

    typedef enum logic [0:0] {
        MSG = 1'b0,
        PAR = 1'b1
    } state_t;

    // One message bit entering the division register: feedback is the
    // incoming bit XOR the register MSB (the x^12 term being reduced).
    function automatic logic [PAR_W-1:0] bch_step(input logic [PAR_W-1:0] r,
                                                  input logic             b);
        logic f;
        f = b ^ r[PAR_W-1];
        return {r[PAR_W-2:0], 1'b0} ^ (f ? GEN_POLY[PAR_W-1:0] : {PAR_W{1'b0}});
    endfunction

    // Fully unrolled division: synthesises to a pure XOR network.
    function automatic logic [PAR_W-1:0] bch_parity(input logic [K-1:0] msg);
        logic [PAR_W-1:0] r;
        r = {PAR_W{1'b0}};
        for (int i = K - 1; i >= 0; i--) begin
            r = bch_step(r, msg[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/bch_if.sv
// bch_if: handshake and data bundle of the BCH encoder.
//   ready_in     downstream ready (serial output advances only when high)
//   valid_in     data_in carries a valid message bit
//   data_in      serial message bit, MSB first
//   data_in_all  parallel message
//   ready_out    encoder accepts a serial message bit this cycle
//   valid_out    data_out carries a valid codeword bit
//   data_out     serial codeword bit
//   data_out_all parallel codeword {message, parity}
// master = bit source / sink side, slave = encoder side.
interface bch_if;
    import bch_pkg::*;

    logic             ready_in;
    logic             valid_in;
    logic             data_in;
    logic [K-1:0]     data_in_all;
    logic             ready_out;
    logic             valid_out;
    logic             data_out;
    logic [N-1:0]     data_out_all;

    modport master (
        output ready_in, valid_in, data_in, data_in_all,
        input  ready_out, valid_out, data_out, data_out_all
    );

    modport slave (
        input  ready_in, valid_in, data_in, data_in_all,
        output ready_out, valid_out, data_out, data_out_all
    );
endinterface

// File: rtl/bch_encoder_lfsr.sv
// bch_encoder_lfsr: 12-bit serial division register of the BCH encoder.
//   clk, rst     clock, asynchronous active-high reset
//   clr_i        load-clear (highest priority)
//   shift_in_i   divide in one message bit (bit_i)
//   shift_out_i  shift parity out, MSB first (zero fill)
//   bit_i        message bit for shift-in
//   msb_o        current register MSB (next parity bit)
module bch_lfsr
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic shift_in_i,
    input  logic shift_out_i,
    input  logic bit_i,
    output logic msb_o
);

    logic [PAR_W-1:0] lfsr_q;
    logic [PAR_W-1:0] lfsr_d;

    // Next-state selection among clear, divide and shift-out modes.
    always_comb begin
        lfsr_d = lfsr_q;
        if (clr_i) begin
            lfsr_d = {PAR_W{1'b0}};
        end else if (shift_in_i) begin
            lfsr_d = bch_step(lfsr_q, bit_i);
        end else if (shift_out_i) begin
            lfsr_d = {lfsr_q[PAR_W-2:0], 1'b0};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // Division register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= {PAR_W{1'b0}};
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign msb_o = lfsr_q[PAR_W-1];

endmodule

// File: rtl/bch_encoder.sv
// bch_encoder: systematic BCH(63,51) encoder with a serial (LFSR, valid/ready)
// path and an independent one-stage parallel path.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  bch_if.slave: serial handshake/data and parallel message/codeword
module bch_encoder
    import bch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    bch_if.slave   bus
);

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          dout_q, dout_d;
    logic [N-1:0]  all_q;

    logic          ready_s;
    logic          clr_s;
    logic          shin_s;
    logic          shout_s;
    logic          msb_s;

    bch_lfsr u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_s),
        .shift_in_i  (shin_s),
        .shift_out_i (shout_s),
        .bit_i       (bus.data_in),
        .msb_o       (msb_s)
    );

    // Serial FSM next-state, handshake and LFSR control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        ready_s = 1'b0;
        clr_s   = 1'b0;
        shin_s  = 1'b0;
        shout_s = 1'b0;
        case (state_q)
            MSG: begin
                ready_s = bus.ready_in;
                if (bus.ready_in) begin
                    if (bus.valid_in) begin
                        shin_s  = 1'b1;
                        dout_d  = bus.data_in;
                        valid_d = 1'b1;
                        if (cnt_q == 6'(K - 1)) begin
                            cnt_d   = 6'd0;
                            state_d = PAR;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end else begin
                        // bubble: nothing accepted, LFSR holds
                        valid_d = 1'b0;
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            PAR: begin
                if (bus.ready_in) begin
                    shout_s = 1'b1;
                    dout_d  = msb_s;
                    valid_d = 1'b1;
                    // after the 12th shift the register is empty again,
                    // so the next message starts from a clean remainder
                    if (cnt_q == 6'(PAR_W - 1)) begin
                        cnt_d   = 6'd0;
                        state_d = MSG;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = MSG;
                cnt_d   = 6'd0;
                valid_d = 1'b0;
                clr_s   = 1'b1;
            end
        endcase
    end

    // Serial state, counter and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MSG;
            cnt_q   <= 6'd0;
            valid_q <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    // Parallel codeword register, free-running and independent of the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_q <= {N{1'b0}};
        end else begin
            all_q <= {bus.data_in_all, bch_parity(bus.data_in_all)};
        end
    end

    assign bus.ready_out    = ready_s;
    assign bus.valid_out    = valid_q;
    assign bus.data_out     = dout_q;
    assign bus.data_out_all = all_q;

endmodule

// File: tb/tb_bch_encoder.sv
// tb_bch_encoder: directed self-checking bench for bch_encoder. Expected
// serial bits are queued when stimulus is accepted and popped when the DUT
// emits a bit; parity expectations come from an independent long division.
module tb_bch_encoder;
    import bch_pkg::*;

    logic clk;
    logic rst;
    bch_if bus ();

    bch_encoder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic        exp_q[$];
    logic        exp_valid = 1'b0;
    logic        exp_data  = 1'b0;
    bit          m_par = 1'b0;
    int          m_cnt = 0;
    logic [50:0] m_msg = '0;
    logic [11:0] out_par = '0;
    logic [11:0] par1;

    // Reference remainder by long division of m(x)*x^12 by g(x).
    function automatic logic [11:0] poly_rem(input logic [50:0] m);
        logic [62:0] r;
        r = {m, 12'b0};
        for (int i = 62; i >= 12; i--) begin
            if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h1539;
        end
        return r[11:0];
    endfunction

    task automatic chk(input string tag, input logic [62:0] obs, input logic [62:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of serial stimulus with scoreboard update and checks.
    task automatic cyc(input logic vin, input logic din, input logic rin);
        logic        pop;
        logic        in_par;
        logic [11:0] p;
        @(negedge clk);
        bus.valid_in = vin;
        bus.data_in  = din;
        bus.ready_in = rin;
        #1;
        chk("ready_out", 63'(bus.ready_out), 63'(m_par ? 1'b0 : rin));
        pop    = 1'b0;
        in_par = m_par;
        if (rin) begin
            if (!m_par) begin
                if (vin) begin
                    exp_q.push_back(din);
                    m_msg = {m_msg[49:0], din};
                    m_cnt++;
                    exp_valid = 1'b1;
                    pop = 1'b1;
                    if (m_cnt == 51) begin
                        p = poly_rem(m_msg);
                        for (int k = 11; k >= 0; k--) exp_q.push_back(p[k]);
                        m_cnt = 0;
                        m_par = 1'b1;
                    end
                end else begin
                    exp_valid = 1'b0;
                end
            end else begin
                pop = 1'b1;
                exp_valid = 1'b1;
                m_cnt++;
                if (m_cnt == 12) begin
                    m_cnt = 0;
                    m_par = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (pop) exp_data = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        chk("valid_out", 63'(bus.valid_out), 63'(exp_valid));
        if (exp_valid) chk("data_out", 63'(bus.data_out), 63'(exp_data));
        if (pop && in_par) out_par = {out_par[10:0], bus.data_out};
    endtask

    // Full codeword with optional ready stall, valid bubble and parity stall.
    task automatic send(input logic [50:0] m, input int st_at, input int st_n,
                        input int bub_at, input int bub_n,
                        input int pst_at, input int pst_n);
        bus.data_in_all = m;
        for (int i = 50; i >= 0; i--) begin
            if (50 - i == st_at) repeat (st_n) cyc(1'b1, m[i], 1'b0);
            if (50 - i == bub_at) repeat (bub_n) cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b1, m[i], 1'b1);
        end
        for (int j = 0; j < 12; j++) begin
            if (j == pst_at) repeat (pst_n) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b1, 1'($urandom), 1'b1);
        end
        chk("serial_parity", 63'(out_par), 63'(poly_rem(m)));
        chk("serial_vs_parallel", 63'(out_par), 63'(bus.data_out_all[11:0]));
        chk("parallel_codeword", bus.data_out_all, {m, poly_rem(m)});
    endtask

    logic [50:0] msg1;
    logic [50:0] msg2;
    logic [50:0] v;
    logic [11:0] ptab [4];

    initial begin
        msg1 = 51'b011111100000110011101001010100011001001011110100100;
        msg2 = {19'($urandom), $urandom};
        ptab[0] = 12'h000; ptab[1] = 12'h539; ptab[2] = 12'hA72; ptab[3] = 12'hF4B;

        bus.valid_in    = 1'b0;
        bus.data_in     = 1'b0;
        bus.ready_in    = 1'b0;
        bus.data_in_all = 51'h5A5A5;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid_out", 63'(bus.valid_out), 63'd0);
        chk("rst_data_out", 63'(bus.data_out), 63'd0);
        chk("rst_data_out_all", bus.data_out_all, 63'd0);
        rst = 1'b0;

        // parallel path: known remainders and linearity
        for (int i = 0; i < 4; i++) begin
            bus.data_in_all = 51'(i);
            cyc(1'b0, 1'b0, 1'b0);
            chk("parallel_known", bus.data_out_all, {51'(i), ptab[i]});
        end
        v = msg2;
        bus.data_in_all = v;
        cyc(1'b0, 1'b0, 1'b0);
        chk("parallel_random", bus.data_out_all, {v, poly_rem(v)});
        chk("pkg_parity_fn", 63'(bch_parity(msg1)), 63'(poly_rem(msg1)));

        // plain codeword, then back-to-back second codeword
        send(msg1, -1, 0, -1, 0, -1, 0);
        par1 = out_par;
        send(msg2, -1, 0, -1, 0, -1, 0);

        // backpressure mid-message and mid-parity
        send(msg1, 20, 3, -1, 0, 5, 2);
        chk("stall_parity", 63'(out_par), 63'(par1));

        // valid bubbles in MSG
        send(msg1, -1, 0, 30, 4, -1, 0);
        chk("bubble_parity", 63'(out_par), 63'(par1));

        // asynchronous reset at bit 20, between clock edges
        bus.data_in_all = msg2;
        for (int i = 0; i < 20; i++) cyc(1'b1, msg1[50 - i], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_out", 63'(bus.valid_out), 63'd0);
        chk("midrst_data_out", 63'(bus.data_out), 63'd0);
        chk("midrst_data_out_all", bus.data_out_all, 63'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_valid = 1'b0;
        exp_data  = 1'b0;
        m_par = 1'b0;
        m_cnt = 0;
        send(msg2, -1, 0, -1, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
